// File: rtl/adsr_env_core.sv
// ADSR envelope generator with a register slot; amp in 32-bit fixed point, env in Q2.14.
// Optional build macro ADSR_PRESCALE_EN adds a tick_div register (addr 6) that slows the update tick.
module adsr_env_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [15:0] env,
    output logic        idle
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [31:0] AMP_MAX = 32'h8000_0000;

    state_t      state, state_nxt;
    logic [31:0] amp, amp_nxt;
    logic [31:0] sus_cnt, sus_cnt_nxt;
    logic [31:0] atk_step, dcy_step, sus_lvl, rel_step, sus_time;
    logic        tick;
    logic        reg_wr, cmd_wr, cmd_abort, cmd_start, cmd_release;
    logic        release_ok;

    // read has no side effects and only addr[2:0] is decoded
    wire unused_ok = &{1'b0, read, addr[4:3]};

    // 33-bit sums so a step larger than the remaining headroom cannot wrap
    function automatic logic attack_done(input logic [31:0] a, input logic [31:0] step);
        return (step == 32'd0) || (({1'b0, a} + {1'b0, step}) >= {1'b0, AMP_MAX});
    endfunction

    function automatic logic decay_done(input logic [31:0] a, input logic [31:0] lvl,
                                        input logic [31:0] step);
        return (step == 32'd0) || ({1'b0, a} <= ({1'b0, lvl} + {1'b0, step}));
    endfunction

    function automatic logic [31:0] sat_level(input logic [31:0] lvl);
        return (lvl > AMP_MAX) ? AMP_MAX : lvl;
    endfunction

    assign reg_wr      = cs & write;
    assign cmd_wr      = reg_wr && (addr[2:0] == 3'd5);
    assign cmd_abort   = cmd_wr & wr_data[2];
    assign cmd_start   = cmd_wr & wr_data[0] & ~wr_data[2];
    assign cmd_release = cmd_wr & wr_data[1] & ~wr_data[0] & ~wr_data[2];
    assign release_ok  = (state == S_ATTACK) || (state == S_DECAY) || (state == S_SUSTAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            atk_step <= '0;
            dcy_step <= '0;
            sus_lvl  <= '0;
            rel_step <= '0;
            sus_time <= '0;
        end else if (reg_wr) begin
            case (addr[2:0])
                3'd0:    atk_step <= wr_data;
                3'd1:    dcy_step <= wr_data;
                3'd2:    sus_lvl  <= wr_data;
                3'd3:    rel_step <= wr_data;
                3'd4:    sus_time <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef ADSR_PRESCALE_EN
    logic [15:0] tick_div, presc;

    assign tick = (presc == tick_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_div <= '0;
            presc    <= '0;
        end else begin
            if (reg_wr && (addr[2:0] == 3'd6))
                tick_div <= wr_data[15:0];
            if (cmd_start || tick)
                presc <= '0;
            else
                presc <= presc + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            amp     <= '0;
            sus_cnt <= '0;
        end else begin
            state   <= state_nxt;
            amp     <= amp_nxt;
            sus_cnt <= sus_cnt_nxt;
        end
    end

    // next state: commands act at the write edge, otherwise the envelope advances on a tick
    always_comb begin
        state_nxt   = state;
        amp_nxt     = amp;
        sus_cnt_nxt = sus_cnt;
        if (cmd_abort) begin
            state_nxt = S_IDLE;
            amp_nxt   = '0;
        end else if (cmd_start) begin
            state_nxt   = S_ATTACK;
            sus_cnt_nxt = '0;
        end else if (cmd_release && release_ok) begin
            state_nxt = S_RELEASE;
        end else if (tick) begin
            case (state)
                S_ATTACK: begin
                    if (attack_done(amp, atk_step)) begin
                        amp_nxt   = AMP_MAX;
                        state_nxt = S_DECAY;
                    end else begin
                        amp_nxt = amp + atk_step;
                    end
                end
                S_DECAY: begin
                    if (decay_done(amp, sat_level(sus_lvl), dcy_step)) begin
                        amp_nxt   = sat_level(sus_lvl);
                        state_nxt = S_SUSTAIN;
                    end else begin
                        amp_nxt = amp - dcy_step;
                    end
                end
                S_SUSTAIN: begin
                    if ((sus_time != 32'd0) && (sus_cnt == sus_time - 32'd1))
                        state_nxt = S_RELEASE;
                    else
                        sus_cnt_nxt = sus_cnt + 32'd1;
                end
                S_RELEASE: begin
                    if ((rel_step == 32'd0) || (amp <= rel_step)) begin
                        amp_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        amp_nxt = amp - rel_step;
                    end
                end
                S_IDLE: begin
                    amp_nxt = '0;
                end
                default: begin
                    amp_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // outputs
    always_comb begin
        idle    = (state == S_IDLE);
        env     = {1'b0, amp[31:17]};
        rd_data = {13'b0, state, 1'b0, amp[31:17]};
    end

endmodule

// File: tb/tb_adsr_env_core.sv
// Bench for adsr_env_core: directed envelope shapes plus randomized register/command traffic
// checked every cycle against a behavioural envelope model.
module tb_adsr_env_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic [15:0] env;
    logic        idle;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    localparam longint MAXL = 64'h8000_0000;

    adsr_env_core dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .env     (env),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    // phases: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    typedef struct packed {
        logic [2:0]  ph;
        logic [31:0] amp;
        logic [31:0] atk;
        logic [31:0] dcy;
        logic [31:0] sus;
        logic [31:0] rel;
        logic [31:0] stime;
        logic [31:0] cnt;
        logic [15:0] tdiv;
        logic [15:0] presc;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(input mdl_t cur, input logic c, input logic w,
                                   input logic [4:0] a, input logic [31:0] d);
        mdl_t   n;
        longint amp, lvl;
        bit     tick, wr, cmd, ab, st, rl;
        n    = cur;
        amp  = longint'(cur.amp);
        lvl  = (longint'(cur.sus) > MAXL) ? MAXL : longint'(cur.sus);
        wr   = c && w;
        cmd  = wr && (a[2:0] == 3'd5);
        ab   = cmd && d[2];
        st   = cmd && d[0] && !d[2];
        rl   = cmd && d[1] && !d[0] && !d[2];
`ifdef ADSR_PRESCALE_EN
        tick = (cur.presc == cur.tdiv);
        n.presc = (st || tick) ? 16'd0 : cur.presc + 16'd1;
`else
        tick = 1'b1;
`endif
        if (wr) begin
            case (a[2:0])
                3'd0: n.atk = d;
                3'd1: n.dcy = d;
                3'd2: n.sus = d;
                3'd3: n.rel = d;
                3'd4: n.stime = d;
`ifdef ADSR_PRESCALE_EN
                3'd6: n.tdiv = d[15:0];
`endif
                default: ;
            endcase
        end
        if (ab) begin
            n.ph = 3'd0;
            amp  = 0;
        end else if (st) begin
            n.ph  = 3'd1;
            n.cnt = '0;
        end else if (rl && (cur.ph inside {3'd1, 3'd2, 3'd3})) begin
            n.ph = 3'd4;
        end else if (tick) begin
            case (cur.ph)
                3'd1: if (cur.atk == 0 || amp + longint'(cur.atk) >= MAXL) begin
                        amp = MAXL; n.ph = 3'd2;
                      end else amp = amp + longint'(cur.atk);
                3'd2: if (cur.dcy == 0 || amp <= lvl + longint'(cur.dcy)) begin
                        amp = lvl; n.ph = 3'd3;
                      end else amp = amp - longint'(cur.dcy);
                3'd3: if (cur.stime != 0 && cur.cnt == cur.stime - 32'd1) n.ph = 3'd4;
                      else n.cnt = cur.cnt + 32'd1;
                3'd4: if (cur.rel == 0 || amp <= longint'(cur.rel)) begin
                        amp = 0; n.ph = 3'd0;
                      end else amp = amp - longint'(cur.rel);
                default: amp = 0;
            endcase
        end
        n.amp = amp[31:0];
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= mstep(m, cs, write, addr, wr_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("model_env", {16'h0, env}, {17'h0, m.amp[31:17]});
            chk("model_idle", {31'h0, idle}, {31'h0, (m.ph == 3'd0)});
            chk("model_rd_data", rd_data, {13'h0, m.ph, 1'b0, m.amp[31:17]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        cyc();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int k = 0;
        while (rd_data[18:16] != s && k < max) begin
            cyc();
            k++;
        end
        chk(name, {29'h0, rd_data[18:16]}, {29'h0, s});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_env", {16'h0, env}, 32'h0);
        chk("reset_idle", {31'h0, idle}, 32'h1);
        chk("reset_rd_data", rd_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_step();
        if ($urandom_range(0, 19) == 0) return 32'h0;
        return $urandom >> $urandom_range(1, 10);
    endfunction

    logic [15:0] atk_exp [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [15:0] dcy_exp [4] = '{16'h3800, 16'h3000, 16'h2800, 16'h2000};

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("por_env", {16'h0, env}, 32'h0);
        chk("por_idle", {31'h0, idle}, 32'h1);
        chk("por_rd_data", rd_data, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // attack / decay / sustain / release shape
        wr(5'd0, 32'h2000_0000);
        wr(5'd1, 32'h1000_0000);
        wr(5'd2, 32'h4000_0000);
        wr(5'd3, 32'h2000_0000);
        wr(5'd4, 32'd3);
        wr(5'd5, 32'h1);
        chk("start_state", {29'h0, rd_data[18:16]}, 32'd1);
        chk("start_env", {16'h0, env}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("attack_env", {16'h0, env}, {16'h0, atk_exp[i]});
        end
        chk("attack_to_decay", {29'h0, rd_data[18:16]}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("decay_env", {16'h0, env}, {16'h0, dcy_exp[i]});
        end
        chk("decay_to_sustain", {29'h0, rd_data[18:16]}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sustain_env", {16'h0, env}, 32'h2000);
        end
        chk("sustain_to_release", {29'h0, rd_data[18:16]}, 32'd4);
        cyc();
        chk("release_env1", {16'h0, env}, 32'h1000);
        cyc();
        chk("release_env0", {16'h0, env}, 32'h0);
        chk("release_idle", {31'h0, idle}, 32'h1);

        // infinite sustain, release write, abort in attack
        wr(5'd4, 32'd0);
        wr(5'd5, 32'h1);
        wait_state(3'd3, 20, "reach_sustain");
        repeat (1000) cyc();
        chk("sustain_hold", {29'h0, rd_data[18:16]}, 32'd3);
        wr(5'd5, 32'h2);
        chk("release_cmd", {29'h0, rd_data[18:16]}, 32'd4);
        wr(5'd5, 32'h1);
        cyc();
        wr(5'd5, 32'h5);
        chk("abort_env", {16'h0, env}, 32'h0);
        chk("abort_idle", {31'h0, idle}, 32'h1);

        // zero attack step jumps to full scale in one tick
        wr(5'd0, 32'h0);
        wr(5'd5, 32'h1);
        cyc();
        chk("atk0_env", {16'h0, env}, 32'h4000);
        chk("atk0_state", {29'h0, rd_data[18:16]}, 32'd2);

        // restart from mid-release
        wr(5'd0, 32'h2000_0000);
        wr(5'd5, 32'h2);
        chk("rel_from_decay", {16'h0, env}, 32'h3800);
        cyc();
        chk("rel_a", {16'h0, env}, 32'h2800);
        cyc();
        chk("rel_b", {16'h0, env}, 32'h1800);
        wr(5'd3, 32'h0800_0000);
        chk("rel_c", {16'h0, env}, 32'h0800);
        wr(5'd5, 32'h1);
        chk("restart_env", {16'h0, env}, 32'h0800);
        chk("restart_state", {29'h0, rd_data[18:16]}, 32'd1);
        cyc();
        chk("restart_ramp", {16'h0, env}, 32'h1800);

        // asynchronous reset while decaying
        wait_state(3'd2, 20, "reach_decay");
        do_reset();

`ifdef ADSR_PRESCALE_EN
        wr(5'd6, 32'd3);
        wr(5'd0, 32'h4000_0000);
        wr(5'd5, 32'h1);
        repeat (3) cyc();
        chk("presc_hold0", {16'h0, env}, 32'h0);
        cyc();
        chk("presc_step1", {16'h0, env}, 32'h2000);
        repeat (3) cyc();
        chk("presc_hold1", {16'h0, env}, 32'h2000);
        cyc();
        chk("presc_step2", {16'h0, env}, 32'h4000);
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            read = 1'($urandom_range(0, 1));
            if (r < 8) begin
                logic [2:0] a;
                logic [31:0] d;
                a = 3'($urandom_range(0, 4));
                case (a)
                    3'd2:    d = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom >> 1);
                    3'd4:    d = 32'($urandom_range(0, 12));
                    default: d = rnd_step();
                endcase
                wr({2'($urandom_range(0, 3)), a}, d);
            end else if (r < 11) begin
                wr({2'($urandom_range(0, 3)), 3'd5}, 32'($urandom_range(0, 7)));
            end else if (r < 12) begin
                wr({2'($urandom_range(0, 3)), 3'($urandom_range(6, 7))}, 32'($urandom_range(0, 3)));
            end else begin
                cs = 1'($urandom_range(0, 1));
                addr = 5'($urandom_range(0, 31));
                wr_data = $urandom;
                cyc();
                cs = 1'b0;
            end
            if (i == 2500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
